// File: rtl/iir_deemph_mc.sv
// ============================================================================
// Module      : iir_deemph_mc
// Description : Multi-channel first-order IIR de-emphasis filter with
//               per-channel history, FIFO handshakes and optional saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iir_deemph_mc #(
    parameter int DEEMPH_DATA_WIDTH = 32,
    parameter int NUM_CH            = 2,
    parameter int FRAC_BITS         = 10,
    parameter int B0                = 178,
    parameter int B1                = 178,
    parameter int A1                = -666,
    parameter int SATURATE          = 1
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic signed [DEEMPH_DATA_WIDTH-1:0]               din,
    input  logic                                              in_empty,
    output logic                                              in_rd_en,
    output logic signed [DEEMPH_DATA_WIDTH-1:0]               dout,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]    dout_ch,
    input  logic                                              out_full,
    output logic                                              out_wr_en,
    input  logic                                              flush
);

    localparam int W    = DEEMPH_DATA_WIDTH;
    localparam int PW   = 2 * W;
    localparam int TW   = W + FRAC_BITS;
    localparam int SW   = TW + 2;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic signed [PW-1:0] C_B0  = PW'(B0);
    localparam logic signed [PW-1:0] C_B1  = PW'(B1);
    localparam logic signed [PW-1:0] C_A1  = PW'(A1);
    localparam logic signed [SW-1:0] C_MAX = SW'({1'b0, {(W-1){1'b1}}});
    localparam logic signed [SW-1:0] C_MIN = ~C_MAX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic signed [W-1:0]    x_q, x_d;
    logic signed [PW-1:0]   p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
    logic signed [W-1:0]    x_prev_q [NUM_CH];
    logic signed [W-1:0]    x_prev_d [NUM_CH];
    logic signed [W-1:0]    y_prev_q [NUM_CH];
    logic signed [W-1:0]    y_prev_d [NUM_CH];
    logic signed [W-1:0]    dout_q, dout_d;
    logic [CH_W-1:0]        dout_ch_q, dout_ch_d;

    logic signed [PW-1:0]   w_xe, w_xpe, w_ype;
    logic signed [TW-1:0]   w_t0, w_t1, w_t2;
    logic signed [SW-1:0]   w_sum;
    logic signed [W-1:0]    w_red;

    assign in_rd_en  = (state_q == S_IDLE) & ~in_empty & ~flush;
    assign out_wr_en = (state_q == S_OUT) & ~out_full;
    assign dout      = dout_q;
    assign dout_ch   = dout_ch_q;

    assign w_xe  = PW'(x_q);
    assign w_xpe = PW'(x_prev_q[ch_q]);
    assign w_ype = PW'(y_prev_q[ch_q]);

    // Arithmetic shift floors each dequantized term toward minus infinity
    assign w_t0  = TW'(p0_q >>> FRAC_BITS);
    assign w_t1  = TW'(p1_q >>> FRAC_BITS);
    assign w_t2  = TW'(p2_q >>> FRAC_BITS);
    assign w_sum = SW'(w_t0) + SW'(w_t1) + SW'(w_t2);

    generate
        if (SATURATE != 0) begin : g_sat
            always_comb begin
                if (w_sum > C_MAX)
                    w_red = {1'b0, {(W-1){1'b1}}};
                else if (w_sum < C_MIN)
                    w_red = {1'b1, {(W-1){1'b0}}};
                else
                    w_red = W'(w_sum);
            end
        end else begin : g_wrap
            assign w_red = W'(w_sum);
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        x_d       = x_q;
        p0_d      = p0_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        x_prev_d  = x_prev_q;
        y_prev_d  = y_prev_q;
        dout_d    = dout_q;
        dout_ch_d = dout_ch_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        x_prev_d[i] = '0;
                        y_prev_d[i] = '0;
                    end
                    ch_d = '0;
                end else if (!in_empty) begin
                    x_d     = din;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                p0_d    = w_xe * C_B0;
                p1_d    = w_xpe * C_B1;
                p2_d    = w_ype * C_A1;
                state_d = S_ACC;
            end
            S_ACC: begin
                dout_d    = w_red;
                dout_ch_d = ch_q;
                state_d   = S_OUT;
            end
            S_OUT: begin
                // History commits only when the sample actually leaves
                if (!out_full) begin
                    x_prev_d[ch_q] = x_q;
                    y_prev_d[ch_q] = dout_q;
                    ch_d    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            x_q       <= '0;
            p0_q      <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            dout_q    <= '0;
            dout_ch_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                x_prev_q[i] <= '0;
                y_prev_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            x_q       <= x_d;
            p0_q      <= p0_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            dout_q    <= dout_d;
            dout_ch_q <= dout_ch_d;
            x_prev_q  <= x_prev_d;
            y_prev_q  <= y_prev_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iir_deemph_mc.sv
// ============================================================================
// Module      : tb_iir_deemph_mc
// Description : Randomized self-checking bench for iir_deemph_mc against an
//               arithmetic reference model (stereo default + 16-bit sat/wrap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iir_deemph_mc;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset, in_empty, out_full, flush;
    logic signed [31:0] din0, dout0;
    logic signed [15:0] din1, dout1, dout2;
    logic [0:0]         dch0, dch1, dch2;
    logic               rd0, rd1, rd2, wr0, wr1, wr2;

    iir_deemph_mc #(.DEEMPH_DATA_WIDTH(32), .NUM_CH(2), .FRAC_BITS(10),
                    .B0(178), .B1(178), .A1(-666), .SATURATE(1)) u_dut (
        .clock(clock), .reset(reset), .din(din0), .in_empty(in_empty),
        .in_rd_en(rd0), .dout(dout0), .dout_ch(dch0), .out_full(out_full),
        .out_wr_en(wr0), .flush(flush));

    iir_deemph_mc #(.DEEMPH_DATA_WIDTH(16), .NUM_CH(1), .FRAC_BITS(10),
                    .B0(2048), .B1(0), .A1(0), .SATURATE(1)) u_sat (
        .clock(clock), .reset(reset), .din(din1), .in_empty(in_empty),
        .in_rd_en(rd1), .dout(dout1), .dout_ch(dch1), .out_full(out_full),
        .out_wr_en(wr1), .flush(flush));

    iir_deemph_mc #(.DEEMPH_DATA_WIDTH(16), .NUM_CH(1), .FRAC_BITS(10),
                    .B0(2048), .B1(0), .A1(0), .SATURATE(0)) u_wrap (
        .clock(clock), .reset(reset), .din(din1), .in_empty(in_empty),
        .in_rd_en(rd2), .dout(dout2), .dout_ch(dch2), .out_full(out_full),
        .out_wr_en(wr2), .flush(flush));

    int     n_checks = 0;
    int     n_pass   = 0;

    // Reference model state, index 0 = stereo filter, 1 = 16-bit sat, 2 = 16-bit wrap
    longint xp [3][2];
    longint yp [3][2];
    int     mch [3];
    longint pend_y [3];
    longint pend_x [3];
    int     pend_ch [3];
    bit     busy;
    int     cnt;
    bit     did_rd, did_wr;
    longint last_w [3];
    longint last_ch0;

    task automatic chk_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic longint model_y(input int inst, input longint x,
                                       input longint xprev, input longint yprev);
        longint b0, b1, a1, s, hi, lo, modv, r;
        int     w;
        bit     sat;
        if (inst == 0) begin
            w = 32; b0 = 178; b1 = 178; a1 = -666; sat = 1'b1;
        end else begin
            w = 16; b0 = 2048; b1 = 0; a1 = 0; sat = (inst == 1);
        end
        s    = ((b0 * x) >>> 10) + ((b1 * xprev) >>> 10) + ((a1 * yprev) >>> 10);
        modv = longint'(1) <<< w;
        hi   = (modv / 2) - 1;
        lo   = -(modv / 2);
        if (sat) begin
            if (s > hi) s = hi;
            else if (s < lo) s = lo;
            return s;
        end
        r = s & (modv - 1);
        if (r > hi) r = r - modv;
        return r;
    endfunction

    function automatic int nch(input int inst);
        return (inst == 0) ? 2 : 1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 2; c++) begin
                xp[i][c] = 0;
                yp[i][c] = 0;
            end
            mch[i] = 0;
        end
    endtask

    // One clock: drive at negedge, check handshakes/data, advance the model
    task automatic step(input bit e, input bit f, input bit fl,
                        input longint d0, input longint d1);
        bit exp_rd, exp_wr, was_idle;
        @(negedge clock);
        in_empty = e; out_full = f; flush = fl;
        din0 = d0[31:0]; din1 = d1[15:0];
        #1;
        was_idle = !busy;
        exp_rd = !busy && !e && !fl;
        exp_wr = busy && (cnt >= 3) && !f;
        did_rd = exp_rd;
        did_wr = exp_wr;
        chk_eq("rd_en_main", longint'(rd0), longint'(exp_rd));
        chk_eq("rd_en_sat",  longint'(rd1), longint'(exp_rd));
        chk_eq("rd_en_wrap", longint'(rd2), longint'(exp_rd));
        chk_eq("wr_en_main", longint'(wr0), longint'(exp_wr));
        chk_eq("wr_en_sat",  longint'(wr1), longint'(exp_wr));
        chk_eq("wr_en_wrap", longint'(wr2), longint'(exp_wr));
        if (busy && cnt >= 3) begin
            chk_eq("dout_main", longint'(dout0), pend_y[0]);
            chk_eq("dout_ch_main", longint'(dch0), longint'(pend_ch[0]));
            chk_eq("dout_sat", longint'(dout1), pend_y[1]);
            chk_eq("dout_wrap", longint'(dout2), pend_y[2]);
        end
        if (exp_wr) begin
            last_w[0] = dout0; last_w[1] = dout1; last_w[2] = dout2;
            last_ch0  = dch0;
            for (int i = 0; i < 3; i++) begin
                xp[i][mch[i]] = pend_x[i];
                yp[i][mch[i]] = pend_y[i];
                mch[i] = (mch[i] + 1) % nch(i);
            end
            busy = 1'b0;
        end else if (busy && cnt < 3) begin
            cnt++;
        end
        if (exp_rd) begin
            pend_x[0] = d0;
            pend_x[1] = d1;
            pend_x[2] = d1;
            for (int i = 0; i < 3; i++) begin
                pend_y[i]  = model_y(i, pend_x[i], xp[i][mch[i]], yp[i][mch[i]]);
                pend_ch[i] = mch[i];
            end
            busy = 1'b1;
            cnt  = 1;
        end
        if (fl && was_idle) model_clear();
    endtask

    task automatic send(input longint d0, input longint d1);
        int guard = 0;
        do begin
            step(1'b0, 1'b0, 1'b0, d0, d1);
            guard++;
        end while (!did_rd && guard < 10);
        if (!did_rd) chk_eq("send_read_timeout", 0, 1);
        guard = 0;
        do begin
            step(1'b1, 1'b0, 1'b0, 0, 0);
            guard++;
        end while (!did_wr && guard < 10);
        if (!did_wr) chk_eq("send_write_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; in_empty = 1'b1; out_full = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        busy = 1'b0; cnt = 0;
        model_clear();
        #1;
        chk_eq("reset_dout", longint'(dout0), 0);
        chk_eq("reset_dout_ch", longint'(dch0), 0);
        chk_eq("reset_wr_en", longint'(wr0), 0);
        chk_eq("reset_rd_en", longint'(rd0), 0);
    endtask

    initial begin
        longint d0, d1;
        reset = 1'b0; in_empty = 1'b1; out_full = 1'b0; flush = 1'b0;
        din0 = '0; din1 = '0;
        busy = 1'b0; cnt = 0;
        model_clear();
        do_reset();

        // Impulse and interleave, plus saturation/wrap on the 16-bit instances
        send(1024, 20000);
        chk_eq("imp_y0", last_w[0], 178);     chk_eq("imp_ch0", last_ch0, 0);
        chk_eq("sat_pos", last_w[1], 32767);  chk_eq("wrap_pos", last_w[2], -25536);
        send(0, -20000);
        chk_eq("imp_ch1_y", last_w[0], 0);    chk_eq("imp_ch1", last_ch0, 1);
        chk_eq("sat_neg", last_w[1], -32768); chk_eq("wrap_neg", last_w[2], 25536);
        send(0, 0);
        chk_eq("imp_y1", last_w[0], 62);
        send(0, 0);
        send(0, 0);
        chk_eq("imp_y2", last_w[0], -41);
        send(0, 0);

        // Flush with a non-empty FIFO in the same cycle must not read
        send(1024, 0);
        step(1'b0, 1'b0, 1'b1, 77, 0);
        send(0, 0);
        chk_eq("flush_y", last_w[0], 0);
        chk_eq("flush_ch", last_ch0, 0);

        // Backpressure held for 5 cycles in OUT
        step(1'b0, 1'b1, 1'b0, 12345, 100);
        repeat (7) step(1'b0, 1'b1, 1'b0, 999, 5);
        step(1'b0, 1'b0, 1'b0, 555, 6);
        chk_eq("bp_one_write", longint'(did_wr), 1);
        step(1'b0, 1'b0, 1'b0, 555, 6);
        chk_eq("bp_next_read", longint'(did_rd), 1);
        repeat (4) step(1'b1, 1'b0, 1'b0, 0, 0);

        // Reset during MUL discards the sample and clears history
        send(1024, 0);
        step(1'b0, 1'b0, 1'b0, 5000, 0);
        do_reset();
        send(1024, 0);
        chk_eq("post_reset_y", last_w[0], 178);
        chk_eq("post_reset_ch", last_ch0, 0);

        // Randomized traffic with backpressure, gaps and occasional flushes
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) d0 = longint'($urandom_range(0, 4095)) - 2048;
            else d0 = longint'(int'($urandom()));
            d1 = longint'($urandom_range(0, 65535)) - 32768;
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 49) == 0, d0, d1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
